// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter: 16 requesters share one one-hot select bus; grant held until release.
// Optional ARB_TIMEOUT_EN macro adds a HOLD_MAX-cycle ownership limit with a preempt pulse.
`timescale 1ns/1ps

module rr_arbiter_16 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_idx,
  output logic        gnt_vld,
  output logic        preempt
);

  localparam int unsigned N     = 16;
  localparam int unsigned IDX_W = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  if (HOLD_MAX == 0 || HOLD_MAX > 255) begin : g_hold_range
    $error("rr_arbiter_16: HOLD_MAX must be in 1..255");
  end

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = 8;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             preempt_q, preempt_d;
`endif

  logic             pick_found_c;
  logic [IDX_W-1:0] pick_idx_c;
  logic [IDX_W-1:0] cand_c;

  // First requester at or above ptr, wrapping 15 -> 0.
  always_comb begin
    pick_found_c = 1'b0;
    pick_idx_c   = '0;
    cand_c       = ptr_q;
    for (int unsigned off = 0; off < N; off++) begin
      cand_c = ptr_q + IDX_W'(off);
      if (!pick_found_c && req[cand_c]) begin
        pick_found_c = 1'b1;
        pick_idx_c   = cand_c;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    preempt_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_found_c) begin
          idx_d   = pick_idx_c;
          gnt_d   = N'(1) << pick_idx_c;
          vld_d   = 1'b1;
          state_d = ST_GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (!req[idx_q]) begin
          gnt_d   = '0;
          vld_d   = 1'b0;
          ptr_d   = idx_q + IDX_W'(1);
          state_d = ST_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        // Owner still requesting at the limit: forced release, owner drops to lowest priority.
        else if (hold_q == CNT_W'(HOLD_MAX - 1)) begin
          gnt_d     = '0;
          vld_d     = 1'b0;
          ptr_d     = idx_q + IDX_W'(1);
          state_d   = ST_IDLE;
          preempt_d = 1'b1;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign preempt = preempt_q;
`else
  assign preempt = 1'b0;
`endif

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;

endmodule
